// File: rtl/druaga_vram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | druaga_vram_arbiter_pkg                                              |
// | Shared constants, CPU FSM encoding and CPU address-map helper.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package druaga_vram_arbiter_pkg;

  localparam logic [2:0] MODEL_SUPERPAC = 3'd5;

  // Slot positions inside the 8-cycle VCLKx8 frame
  localparam logic [2:0] PH_VID_ADDR  = 3'd0;
  localparam logic [2:0] PH_VID_LATCH = 3'd1;
  localparam logic [2:0] PH_CPU_ADDR  = 3'd4;
  localparam logic [2:0] PH_CPU_DONE  = 3'd5;
  localparam logic [2:0] PH_PCE       = 3'd7;

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_PEND = 2'd1,
    CPU_DONE = 2'd2,
    CPU_HOLD = 2'd3
  } cpu_state_t;

  typedef struct packed {
    logic        lane;  // 0 = tile code, 1 = attribute
    logic [10:0] word;
  } cpu_loc_t;

  function automatic cpu_loc_t cpu_map(input logic [2:0]  model,
                                       input logic [2:0]  superpac,
                                       input logic [11:0] ad);
    cpu_loc_t loc;
    if (model == superpac) begin
      loc.lane = ad[10];
      loc.word = {1'b0, ad[9:0]};
    end else begin
      loc.lane = ad[11];
      loc.word = ad[10:0];
    end
    return loc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/druaga_vram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | druaga_vram_arbiter_if                                               |
// | Video read port plus CPU byte port of the BG VRAM arbiter.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface druaga_vram_arbiter_if;

  logic [2:0]  MODEL;
  logic        PCE;
  logic [10:0] VRAM_A;
  logic [15:0] VRAM_D;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [11:0] CPU_AD;
  logic [7:0]  CPU_DI;
  logic [7:0]  CPU_DO;
  logic        CPU_ACK;

  modport master (
    output MODEL, VRAM_A, CPU_REQ, CPU_WE, CPU_AD, CPU_DI,
    input  PCE, VRAM_D, CPU_DO, CPU_ACK
  );

  modport slave (
    input  MODEL, VRAM_A, CPU_REQ, CPU_WE, CPU_AD, CPU_DI,
    output PCE, VRAM_D, CPU_DO, CPU_ACK
  );

endinterface
`default_nettype wire

// File: rtl/druaga_vram_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | druaga_vram_lane                                                     |
// | 2048x8 single-port RAM, registered read, write-first on collision.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module druaga_vram_lane (
  input  wire logic        VCLKx8,
  input  wire logic        we,
  input  wire logic [10:0] addr,
  input  wire logic [7:0]  wdata,
  output logic      [7:0]  rdata
);

  logic [7:0] r_mem [0:2047];

  // Write-first so a CPU write hands back the value it just stored
  always_ff @(posedge VCLKx8) begin
    if (we) begin
      r_mem[addr] <= wdata;
      rdata       <= wdata;
    end else begin
      rdata       <= r_mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/druaga_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | druaga_vram_arbiter                                                  |
// | Shares BG VRAM between video (slot 0/1) and CPU (slot 4/5).          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module druaga_vram_arbiter
  import druaga_vram_arbiter_pkg::*;
#(
  parameter logic [2:0] SUPERPAC = MODEL_SUPERPAC
) (
  input wire logic             VCLKx8,
  input wire logic             RESET,
  druaga_vram_arbiter_if.slave bus
);

  logic [2:0]  r_phase;
  cpu_state_t  r_state;
  cpu_state_t  w_state_nxt;
  cpu_loc_t    r_lat_loc;
  logic        r_lat_we;
  logic [7:0]  r_lat_di;
  logic [15:0] r_vram_d;
  logic [7:0]  r_cpu_do;
  logic        r_cpu_ack;

  logic        w_latch;
  logic        w_access;
  logic        w_done;
  logic [10:0] w_ram_addr;
  logic        w_we_lo;
  logic        w_we_hi;
  logic [7:0]  w_rd_lo;
  logic [7:0]  w_rd_hi;

  always_ff @(posedge VCLKx8 or posedge RESET) begin
    if (RESET) begin
      r_state <= CPU_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_access    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      CPU_IDLE: begin
        if (bus.CPU_REQ) begin
          w_latch     = 1'b1;
          w_state_nxt = CPU_PEND;
        end
      end
      CPU_PEND: begin
        if (r_phase == PH_CPU_ADDR) begin
          w_access    = 1'b1;
          w_state_nxt = CPU_DONE;
        end
      end
      CPU_DONE: begin
        if (r_phase == PH_CPU_DONE) begin
          w_done      = 1'b1;
          w_state_nxt = bus.CPU_REQ ? CPU_HOLD : CPU_IDLE;
        end
      end
      CPU_HOLD: begin
        if (!bus.CPU_REQ) begin
          w_state_nxt = CPU_IDLE;
        end
      end
      default: w_state_nxt = CPU_IDLE;
    endcase
  end

  // Outside the CPU slot the RAM just follows VRAM_A; only the phase-0 read is used
  assign w_ram_addr = w_access ? r_lat_loc.word : bus.VRAM_A;
  assign w_we_lo    = w_access & r_lat_we & ~r_lat_loc.lane;
  assign w_we_hi    = w_access & r_lat_we &  r_lat_loc.lane;

  druaga_vram_lane u_lane_code (
    .VCLKx8 (VCLKx8),
    .we     (w_we_lo),
    .addr   (w_ram_addr),
    .wdata  (r_lat_di),
    .rdata  (w_rd_lo)
  );

  druaga_vram_lane u_lane_attr (
    .VCLKx8 (VCLKx8),
    .we     (w_we_hi),
    .addr   (w_ram_addr),
    .wdata  (r_lat_di),
    .rdata  (w_rd_hi)
  );

  always_ff @(posedge VCLKx8 or posedge RESET) begin
    if (RESET) begin
      r_phase   <= 3'd0;
      r_lat_loc <= '0;
      r_lat_we  <= 1'b0;
      r_lat_di  <= 8'd0;
      r_vram_d  <= 16'd0;
      r_cpu_do  <= 8'd0;
      r_cpu_ack <= 1'b0;
    end else begin
      r_phase   <= r_phase + 3'd1;
      r_cpu_ack <= w_done;
      if (w_latch) begin
        r_lat_loc <= cpu_map(bus.MODEL, SUPERPAC, bus.CPU_AD);
        r_lat_we  <= bus.CPU_WE;
        r_lat_di  <= bus.CPU_DI;
      end
      if (r_phase == PH_VID_LATCH) begin
        r_vram_d <= {w_rd_hi, w_rd_lo};
      end
      if (w_done) begin
        r_cpu_do <= r_lat_loc.lane ? w_rd_hi : w_rd_lo;
      end
    end
  end

  assign bus.PCE     = (r_phase == PH_PCE);
  assign bus.VRAM_D  = r_vram_d;
  assign bus.CPU_DO  = r_cpu_do;
  assign bus.CPU_ACK = r_cpu_ack;

endmodule
`default_nettype wire
